mem_pixel_streamer: RTL and testbench
=====================================

Name: mem_pixel_streamer

Overview:
Sequential image reader that walks a read-only pixel memory (distributed or block ROM) in raster order and emits pixels on a valid/ready stream, tagged with start-of-frame, end-of-line and end-of-frame flags. It replaces free-running address stepping with a start/done controlled, backpressure-safe front end for the edge-detection pipeline. Memory read latency is a parameter, so the same block drives either combinational (spo-style) or registered ROMs.

Parameters:
ADDR_W, 4, memory address width
DATA_W, 8, pixel width
IMG_W, 4, pixels per line; IMG_W*IMG_H <= 2**ADDR_W
IMG_H, 4, lines per frame
RD_LAT, 0, memory read latency in clocks (0, 1 or 2)
BASE_ADDR, 0, address of the first pixel

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse to begin a frame; ignored unless idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last pixel handshakes
mem_addr  out  ADDR_W  registered read address to the memory
mem_rdata  in  DATA_W  memory data, valid RD_LAT clocks after mem_addr
m_valid  out  1  output pixel valid
m_ready  in  1  downstream ready
m_data  out  DATA_W  pixel value
m_sof  out  1  high on the first pixel of the frame
m_eol  out  1  high on the last pixel of each line
m_eof  out  1  high on the last pixel of the frame

Behaviour:
- Reset: state IDLE; busy=0, done=0, m_valid=0, m_data=0, flags=0, mem_addr=BASE_ADDR; FIFO, in-flight pipe and credit count cleared. Reset mid-frame aborts the frame immediately. No done pulse. Pixels in flight are discarded.
- FSM IDLE -> RUN on start. RUN -> DRAIN in the cycle the last address (pixel IMG_W*IMG_H-1) is issued. DRAIN -> IDLE when the FIFO is empty, nothing is in flight and the last pixel has handshaked. done pulses in that same cycle.
- Issue rule (RUN only): a read is issued when occupancy + in_flight < 4. The internal output FIFO has depth 4. On issue, mem_addr advances by 1 and col/row counters step. col wraps at IMG_W-1 and then row increments. There is no wrap past the frame.
- Flags are computed at issue time from (row, col) and travel through an RD_LAT-stage valid/flag shift pipe alongside the read. mem_rdata is captured together with the flags into the FIFO when the pipe output is valid. With RD_LAT=0, capture happens in the issue cycle.
- The credit rule guarantees a FIFO write never occurs when the FIFO is full. Hitting that condition is an assertion failure.
- Output: m_valid = FIFO not empty. m_data and flags are stable while m_valid && !m_ready. A pop occurs on m_valid && m_ready. A simultaneous push and pop at any occupancy, including full and empty, is legal.
- Latency, RD_LAT=0 with m_ready=1: start sampled in cycle 0, address 0 issued in cycle 1, m_valid first high in cycle 2, then 1 pixel/clk. Total frame length is 1 + IMG_W*IMG_H + RD_LAT + 1 cycles to the last handshake.
- With m_ready held low, at most 4 reads are outstanding and issue stalls. Issue resumes the cycle after credit frees.
- start while busy is ignored with no side effects. start in the same cycle as done is ignored. start in the cycle after done begins a new frame.
- With IMG_W=1, m_eol is set on every pixel. With IMG_H=1, m_sof and m_eof fall on line 0.

Decomposition:
- Shared package/header: flag bit positions (SOF, EOL, EOF), FIFO depth constant (4), FSM state encodings (IDLE, RUN, DRAIN).
- One sub-module, stream_fifo: synchronous FIFO, depth 4, width DATA_W+3, sync active-high reset, with push, pop, full, empty and count outputs.

Test Plan:
1. Memory loaded with word = 8'hA0+addr, defaults, m_ready=1, start pulse -> 16 pixels A0..AF on consecutive cycles. m_sof on A0, m_eol on A3/A7/AB/AF, m_eof on AF. done one cycle after AF handshakes, busy low after done.
2. Same frame with m_ready toggling 1,0,0,1 -> identical pixel sequence and flags. Data held while stalled. No pixel lost or duplicated. The FIFO-full assertion never fires.
3. m_ready=0 for 20 cycles after start -> exactly 4 reads issued, mem_addr parks at BASE_ADDR+4. Releasing m_ready drains A0..AF in order.
4. RD_LAT=2, registered ROM model -> the same sequence as test 1. First m_valid is 2 cycles later than in test 1.
5. rst asserted at pixel 7, then start -> m_valid=0 and busy=0 the cycle after rst. The new frame begins at A0 with m_sof. No stale data appears.
6. start pulsed mid-frame and in the done cycle -> both ignored. A start one cycle after done begins frame 2 correctly.

Source files
------------

// File: rtl/mem_pixel_streamer_pkg.sv
// Shared constants for the pixel streamer: flag bit positions, output FIFO depth
// and controller state encodings.
package mem_pixel_streamer_pkg;

   localparam int FLAG_SOF   = 0;
   localparam int FLAG_EOL   = 1;
   localparam int FLAG_EOF   = 2;
   localparam int NUM_FLAGS  = 3;

   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/mem_pixel_streamer_stream_fifo.sv
// Small synchronous FIFO buffering pixel+flag words between memory capture and
// the output stream. Fall-through read port: dout shows the head entry.
module stream_fifo
   import mem_pixel_streamer_pkg::*;
#(
   parameter int WIDTH = 11
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [FIFO_DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]                 count_q, count_d;
   logic                             do_push, do_pop;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/mem_pixel_streamer.sv
// Raster-order ROM reader: issues reads under a FIFO credit limit, carries
// frame flags alongside the read latency and emits pixels on valid/ready.
module mem_pixel_streamer
   import mem_pixel_streamer_pkg::*;
#(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 8,
   parameter int IMG_W     = 4,
   parameter int IMG_H     = 4,
   parameter int RD_LAT    = 0,
   parameter int BASE_ADDR = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_sof,
   output logic              m_eol,
   output logic              m_eof
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int FW    = DATA_W + NUM_FLAGS;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic                issue;
   logic [NUM_FLAGS-1:0] cur_flags;
   logic [CNT_W-1:0]    in_flight;
   logic [CNT_W:0]      credit_used;

   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [FW-1:0]       fifo_din, fifo_dout;
   logic [CNT_W-1:0]    fifo_count;

   // Stage 0 is the issue cycle; stage RD_LAT lines up with mem_rdata.
   logic [RD_LAT:0]                 vld_pipe;
   logic [RD_LAT:0][NUM_FLAGS-1:0]  flg_pipe;

   always_comb begin
      cur_flags           = '0;
      cur_flags[FLAG_SOF] = (row_q == '0) && (col_q == '0);
      cur_flags[FLAG_EOL] = (col_q == COL_W'(IMG_W - 1));
      cur_flags[FLAG_EOF] = cur_flags[FLAG_EOL] && (row_q == ROW_W'(IMG_H - 1));
   end

   assign credit_used = {1'b0, fifo_count} + {1'b0, in_flight};

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      col_d      = col_q;
      row_d      = row_q;
      issue      = 1'b0;
      done       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_RUN;
               mem_addr_d = ADDR_W'(BASE_ADDR);
               col_d      = '0;
               row_d      = '0;
            end
         end
         ST_RUN: begin
            // Reads in flight reserve FIFO space, so capture can never overflow.
            if (credit_used < (CNT_W+1)'(FIFO_DEPTH)) begin
               issue      = 1'b1;
               mem_addr_d = mem_addr_q + 1'b1;
               if (cur_flags[FLAG_EOF]) begin
                  state_d = ST_DRAIN;
               end else if (cur_flags[FLAG_EOL]) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (fifo_empty && (in_flight == '0)) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mem_addr_q <= ADDR_W'(BASE_ADDR);
         col_q      <= '0;
         row_q      <= '0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         col_q      <= col_d;
         row_q      <= row_d;
      end
   end

   assign vld_pipe[0] = issue;
   assign flg_pipe[0] = cur_flags;

   generate
      if (RD_LAT > 0) begin : g_pipe
         logic [RD_LAT:1]                vld_q, vld_d;
         logic [RD_LAT:1][NUM_FLAGS-1:0] flg_q, flg_d;

         always_comb begin
            vld_d = vld_pipe[RD_LAT-1:0];
            flg_d = flg_pipe[RD_LAT-1:0];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= '0;
               flg_q <= '0;
            end else begin
               vld_q <= vld_d;
               flg_q <= flg_d;
            end
         end

         assign vld_pipe[RD_LAT:1] = vld_q;
         assign flg_pipe[RD_LAT:1] = flg_q;

         always_comb begin
            in_flight = '0;
            for (int i = 1; i <= RD_LAT; i++) begin
               in_flight = in_flight + CNT_W'(vld_q[i]);
            end
         end
      end else begin : g_nopipe
         assign in_flight = '0;
      end
   endgenerate

   assign fifo_push = vld_pipe[RD_LAT];
   assign fifo_din  = {flg_pipe[RD_LAT], mem_rdata};
   assign fifo_pop  = m_valid && m_ready;

   stream_fifo #(.WIDTH(FW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(fifo_push && fifo_full && !fifo_pop));

   // Outputs read as zero whenever nothing is presented, including after reset.
   assign busy     = (state_q != ST_IDLE);
   assign mem_addr = mem_addr_q;
   assign m_valid  = !fifo_empty;
   assign m_data   = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
   assign m_sof    = !fifo_empty && fifo_dout[DATA_W + FLAG_SOF];
   assign m_eol    = !fifo_empty && fifo_dout[DATA_W + FLAG_EOL];
   assign m_eof    = !fifo_empty && fifo_dout[DATA_W + FLAG_EOF];

endmodule

// File: tb/tb_mem_pixel_streamer.sv
// Bench for mem_pixel_streamer: one instance on a combinational ROM, one on a
// two-stage registered ROM, both scoreboarded against the expected raster frame.
module tb_mem_pixel_streamer;

   typedef struct packed {
      logic       eof;
      logic       eol;
      logic       sof;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mrdy = 1'b1;
   logic       start [2];
   logic       mv [2], sof [2], eol [2], eof [2], busy [2], dn [2];
   logic [7:0] md [2];
   logic [3:0] maddr [2];
   logic [7:0] rdata0, rdata2, rom_s1;

   int   cyc = 0;
   int   n_chk = 0, n_pass = 0;
   int   hs [2];
   int   fv [2], dc [2], hs_base [2], park_hs [2], busy_after [2];
   logic [3:0] park_addr [2];
   int   s_cyc;
   exp_t q0 [$], q1 [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rdata0 = 8'hA0 + {4'h0, maddr[0]};
   always @(posedge clk) begin
      rom_s1 <= 8'hA0 + {4'h0, maddr[1]};
      rdata2 <= rom_s1;
   end

   mem_pixel_streamer #(.ADDR_W(4), .DATA_W(8), .IMG_W(4), .IMG_H(4), .RD_LAT(0), .BASE_ADDR(0)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(dn[0]),
      .mem_addr(maddr[0]), .mem_rdata(rdata0), .m_valid(mv[0]), .m_ready(mrdy),
      .m_data(md[0]), .m_sof(sof[0]), .m_eol(eol[0]), .m_eof(eof[0]));

   mem_pixel_streamer #(.ADDR_W(4), .DATA_W(8), .IMG_W(4), .IMG_H(4), .RD_LAT(2), .BASE_ADDR(0)) u2 (
      .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(dn[1]),
      .mem_addr(maddr[1]), .mem_rdata(rdata2), .m_valid(mv[1]), .m_ready(mrdy),
      .m_data(md[1]), .m_sof(sof[1]), .m_eol(eol[1]), .m_eof(eof[1]));

   task automatic push_frame(input int d);
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         e.data = 8'hA0 + 8'(i);
         e.sof  = (i == 0);
         e.eol  = (i % 4 == 3);
         e.eof  = (i == 15);
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   // Pops the scoreboard on every handshake and checks stall stability.
   task automatic monitor();
      exp_t e, got;
      logic have;
      logic hv [2];
      exp_t hd [2];
      hv[0] = 1'b0; hv[1] = 1'b0; hd[0] = '0; hd[1] = '0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            got = {eof[d], eol[d], sof[d], md[d]};
            if (hv[d] && mv[d]) begin
               n_chk++;
               if (got !== hd[d]) $display("FAIL hold dut%0d got %h want %h", d, got, hd[d]);
               else n_pass++;
            end
            if (mv[d] && mrdy) begin
               hs[d]++;
               n_chk++;
               have = 1'b0;
               e = '0;
               if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
               else if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
               if (!have) $display("FAIL extra_pixel dut%0d got %h want none", d, got);
               else if (got !== e) $display("FAIL pixel dut%0d got %h want %h", d, got, e);
               else n_pass++;
            end
            hv[d] = mv[d] && !mrdy;
            hd[d] = got;
         end
      end
   endtask

   // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: ready low for 21 cycles.
   task automatic run_frame(input int mode);
      @(posedge clk); #1;
      s_cyc = cyc;
      for (int d = 0; d < 2; d++) begin
         fv[d] = -1; dc[d] = -1; hs_base[d] = hs[d]; park_hs[d] = -1; park_addr[d] = 4'hx;
      end
      push_frame(0);
      push_frame(1);
      for (int k = 0; k < 80; k++) begin
         start[0] = (k == 0);
         start[1] = (k == 0);
         case (mode)
            1:       mrdy = (k % 4 == 0) || (k % 4 == 3);
            2:       mrdy = (k > 20);
            default: mrdy = 1'b1;
         endcase
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (mv[d] && fv[d] < 0) fv[d] = cyc;
            if (dn[d] && dc[d] < 0) dc[d] = cyc;
            if (k == 20) begin park_addr[d] = maddr[d]; park_hs[d] = hs[d] - hs_base[d]; end
         end
         if (dc[0] >= 0 && dc[1] >= 0) break;
         @(posedge clk); #1;
      end
      start[0] = 1'b0; start[1] = 1'b0; mrdy = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) busy_after[d] = busy[d];
   endtask

   task automatic test_reset();
      rst = 1'b1; mrdy = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({busy[d], dn[d], mv[d], sof[d], eol[d], eof[d], md[d], maddr[d]} !== 18'h0)
            $display("FAIL reset_state dut%0d got %h want 0", d,
                     {busy[d], dn[d], mv[d], sof[d], eol[d], eof[d], md[d], maddr[d]});
         else n_pass++;
      end
   endtask

   task automatic test_stream();
      run_frame(0);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (fv[d] - s_cyc !== 2 + 2*d) $display("FAIL first_valid dut%0d got %0d want %0d", d, fv[d] - s_cyc, 2 + 2*d);
         else n_pass++;
         n_chk++;
         if (dc[d] - s_cyc !== 18 + 2*d) $display("FAIL done_cycle dut%0d got %0d want %0d", d, dc[d] - s_cyc, 18 + 2*d);
         else n_pass++;
         n_chk++;
         if (hs[d] - hs_base[d] !== 16) $display("FAIL pixel_count dut%0d got %0d want 16", d, hs[d] - hs_base[d]);
         else n_pass++;
         n_chk++;
         if (busy_after[d] !== 0) $display("FAIL busy_after_done dut%0d got %0d want 0", d, busy_after[d]);
         else n_pass++;
      end
      n_chk++;
      if (q0.size() + q1.size() !== 0) $display("FAIL stream_leftover got %0d want 0", q0.size() + q1.size());
      else n_pass++;
   endtask

   task automatic test_backpressure();
      run_frame(1);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (dc[d] < 0) $display("FAIL bp_done dut%0d got timeout want done", d);
         else n_pass++;
         n_chk++;
         if (hs[d] - hs_base[d] !== 16) $display("FAIL bp_count dut%0d got %0d want 16", d, hs[d] - hs_base[d]);
         else n_pass++;
      end
      n_chk++;
      if (q0.size() + q1.size() !== 0) $display("FAIL bp_leftover got %0d want 0", q0.size() + q1.size());
      else n_pass++;
   endtask

   task automatic test_stall();
      run_frame(2);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (park_addr[d] !== 4'd4) $display("FAIL park_addr dut%0d got %0d want 4", d, park_addr[d]);
         else n_pass++;
         n_chk++;
         if (park_hs[d] !== 0) $display("FAIL stall_leak dut%0d got %0d want 0", d, park_hs[d]);
         else n_pass++;
         n_chk++;
         if (dc[d] < 0 || hs[d] - hs_base[d] !== 16)
            $display("FAIL stall_drain dut%0d got %0d pixels want 16", d, hs[d] - hs_base[d]);
         else n_pass++;
      end
      n_chk++;
      if (q0.size() + q1.size() !== 0) $display("FAIL stall_leftover got %0d want 0", q0.size() + q1.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int base;
      logic hit;
      @(posedge clk); #1;
      push_frame(0); push_frame(1);
      base = hs[0]; hit = 1'b0;
      start[0] = 1'b1; start[1] = 1'b1; mrdy = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0; start[1] = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (hs[0] - base >= 7) begin hit = 1'b1; break; end
         @(posedge clk); #1;
      end
      n_chk++;
      if (!hit) $display("FAIL reach_pixel7 got %0d want 7", hs[0] - base);
      else n_pass++;
      @(posedge clk); #1;
      mrdy = 1'b0; rst = 1'b1;
      q0.delete(); q1.delete();
      @(posedge clk); #1;
      rst = 1'b0; mrdy = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({mv[d], busy[d]} !== 2'b00) $display("FAIL mid_reset dut%0d got valid=%0d busy=%0d want 0 0", d, mv[d], busy[d]);
         else n_pass++;
      end
      run_frame(0);
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (fv[d] - s_cyc !== 2 + 2*d || hs[d] - hs_base[d] !== 16)
            $display("FAIL post_reset_frame dut%0d got lat=%0d n=%0d want lat=%0d n=16", d, fv[d] - s_cyc, hs[d] - hs_base[d], 2 + 2*d);
         else n_pass++;
      end
   endtask

   task automatic test_start_ignore();
      int nd [2];
      @(posedge clk); #1;
      s_cyc = cyc;
      push_frame(0); push_frame(1);
      for (int d = 0; d < 2; d++) begin nd[d] = 0; dc[d] = -1; hs_base[d] = hs[d]; end
      mrdy = 1'b1;
      for (int k = 0; k < 50; k++) begin
         start[0] = (k == 0) || (k == 8) || (k == 18) || (k == 19);
         start[1] = (k == 0) || (k == 8) || (k == 20) || (k == 21);
         if (k == 19) push_frame(0);
         if (k == 21) push_frame(1);
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (dn[d]) begin
               nd[d]++;
               if (nd[d] == 2) dc[d] = cyc;
            end
         end
         @(posedge clk); #1;
      end
      start[0] = 1'b0; start[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (nd[d] !== 2) $display("FAIL done_pulses dut%0d got %0d want 2", d, nd[d]);
         else n_pass++;
         n_chk++;
         if (dc[d] - s_cyc !== (d == 0 ? 37 : 41))
            $display("FAIL frame2_done dut%0d got %0d want %0d", d, dc[d] - s_cyc, (d == 0 ? 37 : 41));
         else n_pass++;
         n_chk++;
         if (hs[d] - hs_base[d] !== 32) $display("FAIL two_frame_count dut%0d got %0d want 32", d, hs[d] - hs_base[d]);
         else n_pass++;
      end
      n_chk++;
      if (q0.size() + q1.size() !== 0) $display("FAIL ignore_leftover got %0d want 0", q0.size() + q1.size());
      else n_pass++;
   endtask

   initial begin
      start[0] = 1'b0; start[1] = 1'b0;
      hs[0] = 0; hs[1] = 0;
      fork
         monitor();
      join_none
      test_reset();
      test_stream();
      test_backpressure();
      test_stall();
      test_reset_mid();
      test_start_ignore();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
